// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
// No timing of its own; pure declarations plus the LFSR feedback helper.
// No flow control; consumed by f1_start_seq and lfsr16.
package f1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HOLD,
    ST_GO,
    ST_DONE,
    ST_FAULT
  } f1_state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic lfsr_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/f1_start_seq_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to randomise the hold delay.
// Advances every clk; q reflects the register directly (zero latency).
// No backpressure; never stalls.
module lfsr16
  import f1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;

  // Shift left every cycle, feeding the tap parity into bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= seed;
    else     q_q <= {q_q[14:0], lfsr_fb(q_q)};
  end

  assign q = q_q;

endmodule

// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: fill lamps, random/fixed hold, lights out, time reaction.
// trigger -> busy in 1 clk; every phase advances only on en ticks, react acts on any clk.
// No backpressure; en gaps stretch all phases, react is never gated.
module f1_start_seq
  import f1_pkg::*;
#(
  parameter int          NUM_LIGHTS = 8,
  parameter int          DELAY_W    = 7,
  parameter int          REACT_W    = 16,
  parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  trigger,
  input  logic                  react,
  input  logic [DELAY_W-1:0]    fixed_delay,
  output logic [NUM_LIGHTS-1:0] data_out,
  output logic                  busy,
  output logic                  go,
  output logic                  react_valid,
  output logic [REACT_W-1:0]    react_time,
  output logic                  jump_start
);

  localparam int LIT_W = $clog2(NUM_LIGHTS + 1);
  localparam logic [LIT_W-1:0] LIT_LAST = LIT_W'(NUM_LIGHTS - 1);
  localparam logic [LIT_W-1:0] LIT_FULL = LIT_W'(NUM_LIGHTS);

  f1_state_t            state_q, state_d;
  logic [LIT_W-1:0]     lit_q, lit_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [REACT_W-1:0]   rtime_q, rtime_d;
  logic [REACT_W-1:0]   react_time_q, react_time_d;
  logic [15:0]          lfsr_q;
  logic [DELAY_W-1:0]   delay_ld;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Hold length: fixed value if given, else the low LFSR bits; never zero.
  always_comb begin
    delay_ld = (fixed_delay != '0) ? fixed_delay : DELAY_W'(lfsr_q);
    if (delay_ld == '0) delay_ld = DELAY_W'(1);
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lit_q        <= '0;
      delay_q      <= '0;
      rtime_q      <= '0;
      react_time_q <= '0;
    end else begin
      state_q      <= state_d;
      lit_q        <= lit_d;
      delay_q      <= delay_d;
      rtime_q      <= rtime_d;
      react_time_q <= react_time_d;
    end
  end

  // Next-state logic. delay_q is left at 1 on the HOLD->GO edge and cleared in
  // GO, so a nonzero delay in GO marks the first GO cycle. In FAULT, lit_q[0]
  // is reused as the flash phase.
  always_comb begin
    state_d      = state_q;
    lit_d        = lit_q;
    delay_d      = delay_q;
    rtime_d      = rtime_q;
    react_time_d = react_time_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_FILL;
          lit_d   = '0;
        end
      end
      ST_FILL: begin
        if (react) begin
          state_d = ST_FAULT;
          lit_d   = '0;
        end else if (en) begin
          if (lit_q == LIT_LAST) begin
            state_d = ST_HOLD;
            lit_d   = LIT_FULL;
            delay_d = delay_ld;
          end else begin
            lit_d = lit_q + LIT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (react) begin
          state_d = ST_FAULT;
          lit_d   = '0;
        end else if (en) begin
          if (delay_q == DELAY_W'(1)) begin
            state_d = ST_GO;
            rtime_d = '0;
          end else begin
            delay_d = delay_q - DELAY_W'(1);
          end
        end
      end
      ST_GO: begin
        delay_d = '0;
        if (react) begin
          state_d      = ST_DONE;
          react_time_d = rtime_q;
        end else if (rtime_q == '1) begin
          state_d      = ST_DONE;
          react_time_d = '1;
        end else if (en) begin
          rtime_d = rtime_q + REACT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (en) lit_d[0] = ~lit_q[0];
        if (!trigger && !react) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    data_out = '0;
    unique case (state_q)
      ST_FILL: begin
        for (int i = 0; i < NUM_LIGHTS; i++) data_out[i] = (i < int'(lit_q));
      end
      ST_HOLD:  data_out = '1;
      ST_FAULT: data_out = lit_q[0] ? '0 : '1;
      default:  data_out = '0;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign go          = (state_q == ST_GO) && (delay_q != '0);
  assign react_valid = (state_q == ST_DONE);
  assign jump_start  = (state_q == ST_FAULT);
  assign react_time  = react_time_q;

endmodule

// File: tb/tb_f1_start_seq.sv
// Directed bench for f1_start_seq with 5 lamps and a 4-bit reaction counter.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Hold length under LFSR control is predicted by an independent LFSR model.
module tb_f1_start_seq;

  localparam int NL = 5;
  localparam int DW = 7;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          trigger;
  logic          react;
  logic [DW-1:0] fixed_delay;
  logic [NL-1:0] data_out;
  logic          busy;
  logic          go;
  logic          react_valid;
  logic [RW-1:0] react_time;
  logic          jump_start;

  int tests = 0;
  int fails = 0;
  int ph    = 0;

  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  f1_start_seq #(
    .NUM_LIGHTS (NL),
    .DELAY_W    (DW),
    .REACT_W    (RW),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .trigger     (trigger),
    .react       (react),
    .fixed_delay (fixed_delay),
    .data_out    (data_out),
    .busy        (busy),
    .go          (go),
    .react_valid (react_valid),
    .react_time  (react_time),
    .jump_start  (jump_start)
  );

  // Reference LFSR: taps 16,14,13,11, shifting left, seed on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // en high on every 4th clock.
  task automatic tick4();
    en = (ph % 4 == 0);
    ph++;
    tick();
  endtask

  initial begin
    logic [31:0] exp;
    logic [15:0] lf_before;
    int          found;
    int          done;
    int          hold_cyc;
    int          d_exp;

    rst = 1'b1; en = 1'b0; trigger = 1'b0; react = 1'b0; fixed_delay = '0;

    // 1: reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_go", go, 0);
    chk("rst_react_valid", react_valid, 0);
    chk("rst_react_time", react_time, 0);
    chk("rst_jump_start", jump_start, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_all_zero", {data_out, busy, go, react_valid, react_time, jump_start}, 0);
    end

    // 2: fixed hold of 3, react in 5th GO cycle
    en = 1'b1; fixed_delay = 7'd3; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("t2_busy", busy, 1);
    chk("t2_fill0", data_out, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp = (32'd1 << i) - 32'd1;
      chk("t2_fill", data_out, exp);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold", data_out, 5'h1F);
    end
    tick();
    chk("t2_go_dat", data_out, 0);
    chk("t2_go", go, 1);
    tick();
    chk("t2_go_once", go, 0);
    repeat (3) tick();
    react = 1'b1;
    tick();
    chk("t2_valid", react_valid, 1);
    chk("t2_time", react_time, 4);
    chk("t2_done_busy", busy, 1);
    react = 1'b0;
    tick();
    chk("t2_valid_drop", react_valid, 0);
    chk("t2_idle_busy", busy, 0);
    chk("t2_time_held", react_time, 4);

    // 3: jump start in 2nd HOLD cycle
    trigger = 1'b1;
    tick();
    repeat (5) tick();
    chk("t3_hold1", data_out, 5'h1F);
    tick();
    react = 1'b1;
    tick();
    chk("t3_js", jump_start, 1);
    chk("t3_flash0", data_out, 5'h1F);
    tick();
    chk("t3_flash1", data_out, 0);
    tick();
    chk("t3_flash2", data_out, 5'h1F);
    react = 1'b0;
    tick();
    chk("t3_trig_holds_fault", jump_start, 1);
    chk("t3_flash3", data_out, 0);
    trigger = 1'b0;
    tick();
    chk("t3_exit_js", jump_start, 0);
    chk("t3_exit_busy", busy, 0);
    chk("t3_exit_dat", data_out, 0);
    chk("t3_time_held", react_time, 4);

    // 4: no reaction, counter times out at 4'hF
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (8) tick();
    chk("t4_go", go, 1);
    repeat (15) tick();
    chk("t4_still_go", react_valid, 0);
    chk("t4_busy", busy, 1);
    tick();
    chk("t4_valid", react_valid, 1);
    chk("t4_time", react_time, 4'hF);
    tick();
    chk("t4_idle", busy, 0);

    // 5: LFSR hold with en every 4th cycle
    en = 1'b0; fixed_delay = '0;
    trigger = 1'b1;
    tick4();
    trigger = 1'b0;
    found = 0;
    lf_before = '0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      lf_before = m_lfsr;
      tick4();
      if (data_out == 5'h1F) found = 1;
    end
    chk("t5_hold_entry", found, 1);
    d_exp = int'(lf_before[6:0]);
    if (d_exp == 0) d_exp = 1;
    hold_cyc = 1;
    done = 0;
    for (int i = 0; i < 1000 && done == 0; i++) begin
      tick4();
      if (data_out == 5'h1F) hold_cyc++;
      else done = 1;
    end
    chk("t5_hold_len", hold_cyc, 4 * d_exp);
    chk("t5_go", go, 1);
    react = 1'b1;
    tick4();
    chk("t5_valid", react_valid, 1);
    react = 1'b0;
    tick4();
    chk("t5_idle", busy, 0);

    // 5b: asynchronous reset in the middle of HOLD
    trigger = 1'b1;
    tick4();
    trigger = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      tick4();
      if (data_out == 5'h1F) found = 1;
    end
    chk("t5b_hold_entry", found, 1);
    tick4();
    tick4();
    chk("t5b_mid_hold", data_out, 5'h1F);
    #2;
    rst = 1'b1;
    #1;
    chk("t5b_rst_dat", data_out, 0);
    chk("t5b_rst_busy", busy, 0);
    chk("t5b_rst_time", react_time, 0);
    #3;
    rst = 1'b0;
    tick();
    chk("t5b_after_rst", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
